down_count_checker: RTL and testbench

Self-checking monitor that sits directly downstream of the 4-bit lab down counters and consumes their count outputs. Every enabled cycle it predicts the next code from the previous sample, compares the prediction against the observed code, and reports mismatches, illegal codes and wrap-arounds on LED-friendly registered outputs. It runs on the same divided clock as the counter under test, so it can validate the binary and Johnson counters on the board without a logic analyser.

---
 rtl/down_count_checker.sv | 86 ++++++++
 tb/tb_down_count_checker.sv | 133 +++++++++++++
 2 files changed

// File: rtl/down_count_checker.sv
// down_count_checker: predicts and checks binary/Johnson down-counter sequences.
// Optional wrap counter is built when DCC_WRAP_COUNT_EN is defined; otherwise wrap_cnt is 0.
module down_count_checker #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     count,
    output logic                 locked,
    output logic                 err,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     last_bad,
    output logic [7:0]           wrap_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_FAULT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, exp_code, trans;
    logic             mode_q, mode_chg, cmp, bad_code, mismatch;

    // Prediction, Johnson legality (at most one adjacent-bit transition) and sample classification
    always_comb begin
        exp_code  = mode ? {prev[WIDTH-2:0], ~prev[WIDTH-1]} : prev - WIDTH'(1);
        trans     = {1'b0, count[WIDTH-1:1] ^ count[WIDTH-2:0]};
        bad_code  = mode && ((trans & (trans - WIDTH'(1))) != '0);
        mode_chg  = (state != S_IDLE) && (mode != mode_q);
        cmp       = en && (state != S_IDLE) && !mode_chg;
        mismatch  = cmp && ((count != exp_code) || bad_code);
        state_nxt = state;
        if (en)
            state_nxt = (state == S_IDLE) ? S_TRACK : mode_chg ? S_IDLE : mismatch ? S_FAULT : state;
    end

    // State register with registered locked indication
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            locked <= state_nxt != S_IDLE;
        end
    end

    // Baseline tracking, sticky flags and saturating error counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev     <= '0;
            mode_q   <= 1'b0;
            err      <= 1'b0;
            illegal  <= 1'b0;
            err_cnt  <= '0;
            last_bad <= '0;
        end else if (en) begin
            prev   <= count;
            mode_q <= mode;
            if (mismatch) begin
                err      <= 1'b1;
                last_bad <= count;
                if (err_cnt != '1)
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
            if (cmp && bad_code)
                illegal <= 1'b1;
        end
    end

`ifdef DCC_WRAP_COUNT_EN
    logic wrap;
    assign wrap = cmp && !mismatch && (prev == (mode ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}}));

    // Count correctly observed wrap transitions, modulo 256
    always_ff @(posedge clk) begin
        if (!rst)
            wrap_cnt <= '0;
        else if (wrap)
            wrap_cnt <= wrap_cnt + 8'd1;
    end
`else
    assign wrap_cnt = '0;
`endif
endmodule

// File: tb/tb_down_count_checker.sv
// tb_down_count_checker: table-driven and directed checks of down_count_checker.
module tb_down_count_checker;
`ifdef DCC_WRAP_COUNT_EN
    localparam bit WRAP_ON = 1'b1;
`else
    localparam bit WRAP_ON = 1'b0;
`endif

    typedef struct {
        logic       r, e, m;
        logic [3:0] c;
        logic       l, er, il;
        logic [7:0] ec;
        logic [3:0] lb;
        logic [7:0] wc;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, mode = 1'b0;
    logic [3:0] count = '0;
    logic       locked, err, illegal;
    logic [7:0] err_cnt, wrap_cnt;
    logic [3:0] last_bad;
    int         checks = 0, errors = 0;
    vec_t       vecs[$];

    down_count_checker #(.WIDTH(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .count(count),
        .locked(locked), .err(err), .illegal(illegal),
        .err_cnt(err_cnt), .last_bad(last_bad), .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic add(input logic r, e, m, input logic [3:0] c, input logic l, er, il,
                       input logic [7:0] ec, input logic [3:0] lb, input logic [7:0] wc);
        vec_t v;
        v = '{r, e, m, c, l, er, il, ec, lb, wc};
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, e, m, input logic [3:0] c);
        rst = r; en = e; mode = m; count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic l, er, il, input logic [7:0] ec,
                           input logic [3:0] lb, input logic [7:0] wc);
        chk({tag, " locked"}, locked, l);
        chk({tag, " err"}, err, er);
        chk({tag, " illegal"}, illegal, il);
        chk({tag, " err_cnt"}, err_cnt, ec);
        chk({tag, " last_bad"}, last_bad, lb);
        chk({tag, " wrap_cnt"}, wrap_cnt, WRAP_ON ? wc : 8'd0);
    endtask

    initial begin
        // Binary sequence 15..0,15,14 with one wrap
        add(0, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++)
            add(1, 1, 0, 4'(15 - i), 1, 0, 0, 0, 0, (i >= 16) ? 8'd1 : 8'd0);
        // Binary single glitch
        add(0, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 4'd9, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 4'd8, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 4'd5, 1, 1, 0, 1, 5, 0);
        add(1, 1, 0, 4'd4, 1, 1, 0, 1, 5, 0);
        add(1, 1, 0, 4'd3, 1, 1, 0, 1, 5, 0);
        // Johnson full cycle, then illegal 0101
        add(0, 1, 1, 4'd0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 4'b0001, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 4'b0011, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 4'b0111, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 4'b1111, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 4'b1110, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 4'b1100, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 4'b1000, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 4'b0000, 1, 0, 0, 0, 0, 1);
        add(1, 1, 1, 4'b0101, 1, 1, 1, 1, 5, 1);

        #2;
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].c);
            chk_all($sformatf("vec%0d", i), vecs[i].l, vecs[i].er, vecs[i].il,
                    vecs[i].ec, vecs[i].lb, vecs[i].wc);
        end

        // en gating: outputs frozen while en is low
        step(0, 1, 0, 4'd0);
        step(1, 1, 0, 4'd10);
        step(1, 1, 0, 4'd9);
        step(1, 1, 0, 4'd3);
        chk_all("glitch", 1, 1, 0, 1, 3, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1'($urandom_range(1)), 4'($urandom_range(15)));
            chk_all($sformatf("en_low%0d", i), 1, 1, 0, 1, 3, 0);
        end
        // Mode change: unlock for one sample, re-baseline, no extra error
        step(1, 1, 1, 4'b0000);
        chk_all("mode_chg", 0, 1, 0, 1, 3, 0);
        step(1, 1, 1, 4'b0001);
        chk_all("rebase", 1, 1, 0, 1, 3, 0);
        step(1, 1, 1, 4'b0011);
        chk_all("jstep", 1, 1, 0, 1, 3, 0);

        // Saturation: baseline plus 300 repeated (mismatching) samples
        step(0, 1, 0, 4'd0);
        for (int i = 0; i < 301; i++) begin
            step(1, 1, 0, 4'd7);
            if (i == 255) chk("sat_edge err_cnt", err_cnt, 8'd255);
        end
        chk_all("sat", 1, 1, 0, 255, 7, 0);
        // Reset mid-operation clears everything
        step(0, 1, 0, 4'd7);
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 4'd3);
        chk_all("post_rst_base", 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 4'd2);
        chk_all("post_rst_step", 1, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
